// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu command front-end:
//   - 4-bit opcode constants understood by the combinational alu datapath
//   - FSM state encoding of alu_cmd_ctrl
//   - result word returned for a divide by zero
//   - packed operation record as stored in the command FIFO
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_INC  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_DEC  = 4'd3;
   localparam logic [3:0] OP_MUL  = 4'd4;
   localparam logic [3:0] OP_DIV  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_INV  = 4'd10;
   localparam logic [3:0] OP_NAND = 4'd11;
   localparam logic [3:0] OP_NOR  = 4'd12;
   localparam logic [3:0] OP_XOR  = 4'd13;
   localparam logic [3:0] OP_XNOR = 4'd14;
   localparam logic [3:0] OP_BUF  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;

   // One buffered operation: {cmd, a, b} = 20 bits.
   typedef struct packed {
      logic [3:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
   } op_t;

   localparam int unsigned OP_WIDTH = $bits(op_t);

   function automatic logic is_div_zero(input logic [3:0] cmd, input logic [7:0] b);
      return (cmd == OP_DIV) && (b == 8'd0);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Small synchronous FIFO holding pending alu operations.
//   clock, reset : shared clock, asynchronous active-high reset
//   push, din    : write din when push is high and the FIFO is not full
//   pop, dout    : dout shows the oldest entry; pop removes it when not empty
//   full, empty  : status decoded from the registered occupancy count
//   count        : occupancy 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = OP_WIDTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Separate count register tells full from empty when the pointers meet.
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign dout    = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// alu_cmd_ctrl
// Command front-end for the combinational alu datapath. Operations arrive on
// a valid/ready port, are buffered in alu_cmd_fifo, issued one at a time to
// the alu, and the captured result is returned on a second valid/ready port.
//
// Handshakes: both ports use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; once res_valid is raised
// res_data/res_cmd/res_err stay stable until that transfer. in_ready depends
// only on registered FIFO state (no same-cycle pop bypass), and res_ready is
// ignored while res_valid is low.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready            request handshake
//   in_a, in_b, in_cmd           operands and opcode
//   alu_a, alu_b, alu_command    stimulus to alu (zero outside EXEC)
//   alu_enable                   high only in EXEC
//   alu_out                      alu result, sampled at the end of EXEC
//   res_valid/res_ready          result handshake
//   res_data, res_cmd, res_err   result, its opcode, divide-by-zero flag
//   dbg_state, dbg_count         FSM state and FIFO occupancy for observation
// ---------------------------------------------------------------------------
module alu_cmd_ctrl
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_a,
   input  logic [7:0]                 in_b,
   input  logic [3:0]                 in_cmd,
   output logic [7:0]                 alu_a,
   output logic [7:0]                 alu_b,
   output logic [3:0]                 alu_command,
   output logic                       alu_enable,
   input  logic [15:0]                alu_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [15:0]                res_data,
   output logic [3:0]                 res_cmd,
   output logic                       res_err,
   output state_t                     dbg_state,
   output logic [$clog2(DEPTH+1)-1:0] dbg_count
);

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [15:0] res_data_q, res_data_d;
   logic [3:0]  res_cmd_q, res_cmd_d;
   logic        res_err_q, res_err_d;

   op_t         fifo_din, fifo_dout;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign fifo_din  = '{cmd: in_cmd, a: in_a, b: in_b};

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (OP_WIDTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (dbg_count)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      res_data_d  = res_data_q;
      res_cmd_d   = res_cmd_q;
      res_err_d   = res_err_q;
      fifo_pop    = 1'b0;
      alu_a       = 8'd0;
      alu_b       = 8'd0;
      alu_command = 4'd0;
      alu_enable  = 1'b0;
      res_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_d     = fifo_dout;
               state_d  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            alu_a       = op_q.a;
            alu_b       = op_q.b;
            alu_command = op_q.cmd;
            alu_enable  = 1'b1;
            res_cmd_d   = op_q.cmd;
            // The alu is still issued on a divide by zero; only the captured
            // result is replaced so the consumer sees a fixed error pattern.
            if (is_div_zero(op_q.cmd, op_q.b)) begin
               res_data_d = DIV_ZERO_RESULT;
               res_err_d  = 1'b1;
            end else begin
               res_data_d = alu_out;
               res_err_d  = 1'b0;
            end
            state_d = ST_RESP;
         end

         ST_RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               // Chain straight into the next operation to keep the
               // EXEC/RESP rhythm at one result every two cycles.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  op_d     = fifo_dout;
                  state_d  = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         res_data_q <= 16'd0;
         res_cmd_q  <= 4'd0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         res_data_q <= res_data_d;
         res_cmd_q  <= res_cmd_d;
         res_err_q  <= res_err_d;
      end
   end

   assign res_data  = res_data_q;
   assign res_cmd   = res_cmd_q;
   assign res_err   = res_err_q;
   assign dbg_state = state_q;

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command front-end for the combinational `alu` datapath. It accepts operations (a, b, command) over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on the `alu` input ports, captures `out`, and returns tagged results over a second valid/ready handshake. It sits between the bus-side requester and `alu`, so the datapath is always driven with clean, registered stimulus.

## Interface
- `DEPTH`, 4: command FIFO depth; must be a power of 2, ≥2.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  requester presents an operation.
- `in_ready`  out  1  FIFO not full; a transfer happens on any edge where `in_valid & in_ready`.
- `in_a`, `in_b`  in  8 each  operands.
- `in_cmd`  in  4  opcode (ADD..BUF, codes 0–15).
- `alu_a`, `alu_b`  out  8 each  operands driven to `alu`.
- `alu_command`  out  4  opcode driven to `alu`.
- `alu_enable`  out  1  `alu` enable.
- `alu_out`  in  16  `alu` result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts; a transfer happens on any edge where `res_valid & res_ready`.
- `res_data`  out  16  result.
- `res_cmd`  out  4  opcode that produced `res_data`.
- `res_err`  out  1  DIV with b == 0.

## Operation
- **FIFO**
  - Written on an accepted `in_*` transfer.
  - Popped only by the FSM.
  - `in_ready = !full`, taken from registered state. A same-cycle pop does not raise `in_ready` in that cycle; there is no bypass path.
- **FSM states:** IDLE, EXEC, RESP.
  - **IDLE:** if the FIFO is non-empty, pop into the op register and go to EXEC. Otherwise stay in IDLE.
  - **EXEC** (exactly 1 cycle):
    - `alu_a`/`alu_b`/`alu_command` are driven from the op register and `alu_enable = 1`.
    - At the closing edge, `alu_out` loads into `res_data`, the opcode into `res_cmd`, and the error flag into `res_err`. Go to RESP.
  - **RESP:** `res_valid = 1` and the result registers are held stable until the handshake.
    - On handshake with the FIFO non-empty: pop and go directly to EXEC.
    - On handshake with the FIFO empty: go to IDLE.
- **Outputs outside EXEC:** `alu_enable = 0` and `alu_a`/`alu_b`/`alu_command` are forced to 0.
- **Divide by zero:** if `command == DIV` and `b == 0`, the ALU is still issued, but `res_data = 16'hFFFF` and `res_err = 1`. In all other cases `res_err = 0` and `res_data = alu_out` exactly as sampled.
- **Ordering:** results are returned in strict acceptance order. No operation is dropped or duplicated.
- **Capacity:** DEPTH in the FIFO, plus 1 in the op register, plus 1 in the result register. The op register and result register are never occupied at the same time.

## Timing
- **Reset values:** `in_ready = 1`, `res_valid = 0`, `res_data = 0`, `res_cmd = 0`, `res_err = 0`, `alu_enable = 0`, `alu_a`/`alu_b`/`alu_command` = 0, FSM in IDLE, FIFO empty.
- **Latency, idle block:** op accepted at edge T → EXEC during cycle T+1 → `res_valid` high after edge T+2.
- **Throughput:** with `res_ready` held at 1 and the FIFO non-empty, one result every 2 cycles (EXEC, RESP alternating).
- **Simultaneous push and pop on a full FIFO:** the push is not accepted, because `in_ready` was 0.
- **Simultaneous push and pop on a non-full FIFO:** both occur; count is unchanged.
- **Pointers:** `log2(DEPTH)` bits, wrapping naturally. Full/empty are distinguished by a separate count register (0..DEPTH).
- **`res_ready` while `res_valid = 0`:** ignored.
- **`reset` asserted mid-operation (any state):** all buffered and in-flight operations are discarded. Outputs go to their reset values asynchronously. The first edge after deassertion behaves as if from IDLE.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants ADD=0, INC=1, SUB=2, DEC=3, MUL=4, DIV=5, SHL=6, SHR=7, AND=8, OR=9, INV=10, NAND=11, NOR=12, XOR=13, XNOR=14, BUF=15;
  - FSM state encoding (IDLE, EXEC, RESP);
  - divide-by-zero result constant 16'hFFFF.
- **Sub-module `alu_cmd_fifo`:**
  - parameterised DEPTH, width 20 (a, b, cmd);
  - ports: push, pop, din, dout, full, empty;
  - same clock and reset as the parent.
- `alu` is not instantiated inside this block. The integration top instantiates both and connects `alu_*` to `alu`.

## Test plan
- **Single op:** ADD a=20, b=10 with `res_ready = 1` → `alu_enable` high for exactly 1 cycle, `res_valid` 2 edges after acceptance, `res_data = 16'd30`, `res_cmd = 0`, `res_err = 0`.
- **Ordering:** back-to-back ADD 25+17, SUB 20-10, ADD 1+1, with `res_ready = 1` → results 42, 10, 2 in order. `res_valid` pulses every 2 cycles.
- **Divide by zero:** DIV a=9, b=0 → `res_err = 1`, `res_data = 16'hFFFF`. A following DIV a=9, b=3 → `res_err = 0`, `res_data` equals the sampled `alu_out`.
- **Backpressure:**
  - Hold `res_ready = 0` and push 6 ops. Ops 1–5 are accepted; `in_ready` falls after the 5th acceptance; `res_data` stays on op 1.
  - Release `res_ready`: all 5 results drain in order, then `in_ready` returns to 1.
- **Simultaneous push/pop:** FIFO at 3/4 with a push and a pop on the same edge → count stays 3 and `in_ready` stays 1.
- **Reset mid-flight:** assert `reset` during EXEC with 2 ops queued → `res_valid` and `alu_enable` drop immediately. After release, nothing emerges until new ops are pushed.
